rab_ar_sender: RTL and testbench
================================

// Module: rab_ar_sender
// PURPOSE
//  Per-port consumer of the RAB lookup decision (accept/drop) for the read-address path.
//  - Accept: forwards the translated AR request onto the master AXI port.
//  - Drop: answers the slave side with len+1 SLVERR R beats instead.
//  - Pulses sent_o when finished, so the lookup FSM can release its decision registers.
//  - One instance per RAB port (port1/port2), between the lookup FSM and the master AR/slave R channels.
// PARAMETERS
//  AXI_ADDR_WIDTH  40  translated (master-side) address width
//  AXI_ID_WIDTH     8  AXI ID width
//  AXI_USER_WIDTH   6  AXI user width
// PORTS
//  Clk_CI          in   1               clock
//  Rst_RBI         in   1               reset, asynchronous, active-low
//  accept_i        in   1               lookup decision: forward request (level, held until after sent_o)
//  drop_i          in   1               lookup decision: reject request (level, held until after sent_o)
//  addr_i          in   AXI_ADDR_WIDTH  translated address
//  id_i            in   AXI_ID_WIDTH    request ID
//  len_i           in   8               burst length - 1
//  user_i          in   AXI_USER_WIDTH  user bits
//  cache_coherent_i in  1               1: ARCACHE=4'b1111, 0: ARCACHE=4'b0000
//  sent_o          out  1               1-cycle pulse: request completed (forwarded or fully error-responded)
//  m_ar_valid_o    out  1               master AR valid
//  m_ar_ready_i    in   1               master AR ready
//  m_ar_addr_o     out  AXI_ADDR_WIDTH  master AR address
//  m_ar_id_o       out  AXI_ID_WIDTH    master AR ID
//  m_ar_len_o      out  8               master AR length
//  m_ar_user_o     out  AXI_USER_WIDTH  master AR user
//  m_ar_cache_o    out  4               master AR cache
//  s_r_valid_o     out  1               error-response R valid
//  s_r_ready_i     in   1               error-response R ready
//  s_r_id_o        out  AXI_ID_WIDTH    error-response R ID
//  s_r_resp_o      out  2               error-response R resp, 2'b10 (SLVERR) while valid
//  s_r_last_o      out  1               error-response R last
// BEHAVIOUR
//  Reset values: state IDLE; all outputs and the beat counter are 0.
//  Reset mid-operation aborts any transfer, with no sent_o pulse.
//  States: IDLE, FORWARD, ERROR.
//  IDLE
//   - drop_i=1 -> register id_i and len_i, clear beat counter, go to ERROR.
//   - Otherwise, accept_i=1 -> register addr/id/len/user/cache, go to FORWARD.
//   - drop_i has priority when both are high.
//  FORWARD
//   - m_ar_valid_o=1 from the cycle after the decision (1-cycle latency).
//   - Payload is stable while valid; valid is never withdrawn before ready.
//   - On m_ar_valid_o & m_ar_ready_i: sent_o=1 in that same cycle (combinational from the handshake), next state IDLE.
//  ERROR
//   - s_r_valid_o=1, s_r_resp_o=2'b10, s_r_id_o = registered ID.
//   - 9-bit beat counter increments on each s_r_valid_o & s_r_ready_i.
//   - s_r_last_o=1 when counter == registered len; sends len+1 beats (1..256).
//   - On the last-beat handshake: sent_o=1 in that cycle, next state IDLE.
//  Re-trigger guard
//   - The decision source clears accept_i/drop_i on the edge that ends the sent_o cycle.
//   - The block re-samples decisions only in IDLE, from the following cycle on.
//   - Never two requests for one decision.
//  Input changes
//   - accept_i/drop_i changes outside IDLE are ignored.
//   - Registered payload is not updated outside IDLE.
//  Output idle values
//   - m_ar_valid_o=0 and s_r_valid_o=0 in IDLE.
//   - s_r_resp_o=0 and s_r_last_o=0 whenever s_r_valid_o=0.
//  Back-to-back: a new decision may be accepted on the first IDLE cycle after sent_o.
// TESTING
//  T1 accept_i, addr=0x12_3456_7000, id=5, len=3, ready held 1 -> m_ar_valid_o 1 cycle later with those values, sent_o same cycle, one AR only.
//  T2 accept_i, ready low 4 cycles -> valid held, payload stable, no sent_o until ready=1; then exactly one sent_o.
//  T3 drop_i, id=9, len=2, s_r_ready=1 -> 3 beats resp=2'b10 id=9, last on beat 3, sent_o with beat 3, no AR.
//  T4 drop_i len=255, random s_r_ready backpressure -> exactly 256 beats, last only on 256th, no AR.
//  T5 accept_i and drop_i both 1 -> error path taken, m_ar_valid_o never asserted.
//  T6 Rst_RBI low mid-ERROR (beat 2 of 4) -> outputs 0 asynchronously; after release IDLE, no sent_o.

Source files
------------

// File: rtl/rab_ar_sender.sv
// RAB read-address sender: turns a lookup accept/drop decision into either one
// master AR request or a burst of len+1 SLVERR R beats, then pulses sent_o.
module rab_ar_sender #(
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int AXI_ID_WIDTH   = 8,
  parameter int AXI_USER_WIDTH = 6
) (
  input  logic                      Clk_CI,
  input  logic                      Rst_RBI,
  input  logic                      accept_i,
  input  logic                      drop_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   id_i,
  input  logic [7:0]                len_i,
  input  logic [AXI_USER_WIDTH-1:0] user_i,
  input  logic                      cache_coherent_i,
  output logic                      sent_o,
  output logic                      m_ar_valid_o,
  input  logic                      m_ar_ready_i,
  output logic [AXI_ADDR_WIDTH-1:0] m_ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   m_ar_id_o,
  output logic [7:0]                m_ar_len_o,
  output logic [AXI_USER_WIDTH-1:0] m_ar_user_o,
  output logic [3:0]                m_ar_cache_o,
  output logic                      s_r_valid_o,
  input  logic                      s_r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]   s_r_id_o,
  output logic [1:0]                s_r_resp_o,
  output logic                      s_r_last_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    ERROR   = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next;
  logic [AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [7:0]                  r_len;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic [3:0]                  r_cache;
  logic [8:0]                  r_cnt;
  logic                        w_ar_hs;
  logic                        w_r_hs;
  logic                        w_last;

  assign w_ar_hs = (r_state == FORWARD) && m_ar_ready_i;
  assign w_r_hs  = (r_state == ERROR) && s_r_ready_i;
  assign w_last  = (r_cnt == {1'b0, r_len});

  // Payload is captured only in IDLE, so it stays frozen for the whole transfer.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_user  <= '0;
      r_cache <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (drop_i) begin
            r_id  <= id_i;
            r_len <= len_i;
            r_cnt <= '0;
          end else if (accept_i) begin
            r_addr  <= addr_i;
            r_id    <= id_i;
            r_len   <= len_i;
            r_user  <= user_i;
            r_cache <= {4{cache_coherent_i}};
          end
        end
        ERROR: begin
          if (w_r_hs) r_cnt <= r_cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next       = r_state;
    sent_o       = 1'b0;
    m_ar_valid_o = 1'b0;
    s_r_valid_o  = 1'b0;
    s_r_resp_o   = 2'b00;
    s_r_last_o   = 1'b0;
    case (r_state)
      IDLE: begin
        if (drop_i)        w_next = ERROR;
        else if (accept_i) w_next = FORWARD;
      end
      FORWARD: begin
        m_ar_valid_o = 1'b1;
        if (w_ar_hs) begin
          sent_o = 1'b1;
          w_next = IDLE;
        end
      end
      ERROR: begin
        s_r_valid_o = 1'b1;
        s_r_resp_o  = 2'b10;
        s_r_last_o  = w_last;
        if (w_r_hs && w_last) begin
          sent_o = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign m_ar_addr_o  = r_addr;
  assign m_ar_id_o    = r_id;
  assign m_ar_len_o   = r_len;
  assign m_ar_user_o  = r_user;
  assign m_ar_cache_o = r_cache;
  assign s_r_id_o     = r_id;

endmodule

// File: tb/tb_rab_ar_sender.sv
// Directed self-checking bench for rab_ar_sender: forward, error, priority,
// backpressure, mid-transfer reset and back-to-back decisions.
module tb_rab_ar_sender;

  localparam int AW = 40;
  localparam int IW = 8;
  localparam int UW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          accept, drop;
  logic [AW-1:0] addr;
  logic [IW-1:0] id;
  logic [7:0]    len;
  logic [UW-1:0] user;
  logic          coh;
  logic          sent;
  logic          arValid, arReady;
  logic [AW-1:0] arAddr;
  logic [IW-1:0] arId;
  logic [7:0]    arLen;
  logic [UW-1:0] arUser;
  logic [3:0]    arCache;
  logic          rValid, rReady;
  logic [IW-1:0] rId;
  logic [1:0]    rResp;
  logic          rLast;

  int nCompared = 0;
  int nMismatch = 0;
  int sentCnt = 0;
  int arCnt = 0;

  always #5 clk = ~clk;

  rab_ar_sender #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n),
    .accept_i(accept), .drop_i(drop),
    .addr_i(addr), .id_i(id), .len_i(len), .user_i(user), .cache_coherent_i(coh),
    .sent_o(sent),
    .m_ar_valid_o(arValid), .m_ar_ready_i(arReady),
    .m_ar_addr_o(arAddr), .m_ar_id_o(arId), .m_ar_len_o(arLen),
    .m_ar_user_o(arUser), .m_ar_cache_o(arCache),
    .s_r_valid_o(rValid), .s_r_ready_i(rReady),
    .s_r_id_o(rId), .s_r_resp_o(rResp), .s_r_last_o(rLast)
  );

  // Running totals of sent pulses and AR handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    if (sent) sentCnt++;
    if (arValid && arReady) arCnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; accept = 0; drop = 0; addr = '0; id = '0; len = '0;
    user = '0; coh = 0; arReady = 0; rReady = 0;
    repeat (2) @(negedge clk);
    nCompared++;
    if ({sent, arValid, arAddr, arId, arLen, arUser, arCache, rValid, rId, rResp, rLast} !== '0) begin
      nMismatch++;
      $display("[TB] FAIL reset_outputs: got nonzero outputs valid=%b/%b sent=%b, expected all 0", arValid, rValid, sent);
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forward();
    int sent0, ar0, lat;
    sent0 = sentCnt; ar0 = arCnt; lat = -1;
    cyc();
    accept = 1; addr = 40'h12_3456_7000; id = 8'd5; len = 8'd3; user = 6'h2A; coh = 1; arReady = 1;
    @(negedge clk);
    nCompared++;
    if (arValid !== 1'b0) begin nMismatch++; $display("[TB] FAIL fwd_decision_cycle: valid=%b expected 0", arValid); end
    for (int i = 0; i < 10; i++) begin
      cyc();
      @(negedge clk);
      if (arValid) begin
        lat = i;
        nCompared++;
        if ({arAddr, arId, arLen, arUser, arCache, sent} !== {40'h12_3456_7000, 8'd5, 8'd3, 6'h2A, 4'hF, 1'b1}) begin
          nMismatch++;
          $display("[TB] FAIL fwd_payload: got addr=%h id=%h len=%h user=%h cache=%h sent=%b", arAddr, arId, arLen, arUser, arCache, sent);
        end
        break;
      end
    end
    nCompared++;
    if (lat !== 0) begin nMismatch++; $display("[TB] FAIL fwd_latency: got %0d expected 0", lat); end
    cyc();
    accept = 0;
    repeat (3) begin cyc(); @(negedge clk); end
    nCompared++;
    if ((arCnt - ar0) !== 1 || (sentCnt - sent0) !== 1) begin
      nMismatch++; $display("[TB] FAIL fwd_single_ar: ar=%0d sent=%0d expected 1/1", arCnt - ar0, sentCnt - sent0);
    end
  endtask

  task automatic test_backpressure();
    int bad, sent0;
    bad = 0; sent0 = sentCnt;
    cyc();
    accept = 1; addr = 40'hAB_CDEF_0123; id = 8'h33; len = 8'd7; user = 6'h05; coh = 0; arReady = 0;
    @(negedge clk);
    cyc();
    addr = 40'h00_0000_0FFF; id = 8'h11; len = 8'd0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) cyc();
      @(negedge clk);
      if (arValid !== 1'b1 || sent !== 1'b0 || arAddr !== 40'hAB_CDEF_0123 || arId !== 8'h33 || arLen !== 8'd7) bad++;
    end
    nCompared++;
    if (bad !== 0) begin nMismatch++; $display("[TB] FAIL bp_hold: got %0d bad cycles expected 0", bad); end
    cyc();
    arReady = 1;
    @(negedge clk);
    nCompared++;
    if ({arValid, sent, arCache, arUser} !== {1'b1, 1'b1, 4'h0, 6'h05}) begin
      nMismatch++; $display("[TB] FAIL bp_release: got valid=%b sent=%b cache=%h user=%h expected 1 1 0 05", arValid, sent, arCache, arUser);
    end
    cyc();
    accept = 0; arReady = 0;
    repeat (2) begin cyc(); @(negedge clk); end
    nCompared++;
    if ((sentCnt - sent0) !== 1 || arValid !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL bp_one_sent: sent=%0d valid=%b expected 1 0", sentCnt - sent0, arValid);
    end
  endtask

  // Runs one error burst of len+1 beats with optional random ready.
  task automatic run_error(input logic [7:0] l, input logic [IW-1:0] expId, input bit both,
                           input bit randReady, input string nm);
    int beats, bad, arSeen;
    bit done;
    beats = 0; bad = 0; arSeen = 0; done = 0;
    cyc();
    drop = 1; accept = both; id = expId; len = l; rReady = 1; arReady = 1;
    @(negedge clk);
    for (int c = 0; c < 2000; c++) begin
      cyc();
      if (randReady) rReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (arValid) arSeen++;
      if (rValid !== 1'b1 || rResp !== 2'b10 || rId !== expId || rLast !== (beats == int'(l))) bad++;
      if (rReady) begin
        if (sent !== (beats == int'(l))) bad++;
        beats++;
      end else if (sent !== 1'b0) bad++;
      if (sent) begin done = 1; break; end
    end
    cyc();
    drop = 0; accept = 0; rReady = 0;
    @(negedge clk);
    nCompared++;
    if (!done || beats !== int'(l) + 1) begin
      nMismatch++; $display("[TB] FAIL %s_beats: got %0d done=%0d expected %0d", nm, beats, done, int'(l) + 1);
    end
    nCompared++;
    if (bad !== 0 || arSeen !== 0) begin
      nMismatch++; $display("[TB] FAIL %s_beat_fields: got bad=%0d ar=%0d expected 0 0", nm, bad, arSeen);
    end
    nCompared++;
    if ({rValid, rResp, rLast, arValid} !== 5'b0) begin
      nMismatch++; $display("[TB] FAIL %s_idle: got valid=%b resp=%b last=%b ar=%b expected 0", nm, rValid, rResp, rLast, arValid);
    end
  endtask

  task automatic test_drop();
    run_error(8'd2, 8'd9, 1'b0, 1'b0, "drop3");
  endtask

  task automatic test_drop_long();
    run_error(8'd255, 8'hC4, 1'b0, 1'b1, "drop256");
  endtask

  task automatic test_priority();
    run_error(8'd0, 8'd3, 1'b1, 1'b0, "prio");
  endtask

  task automatic test_mid_reset();
    int sent0;
    sent0 = sentCnt;
    cyc();
    drop = 1; id = 8'h5A; len = 8'd3; rReady = 1;
    @(negedge clk);
    cyc(); @(negedge clk);
    cyc(); @(negedge clk);
    nCompared++;
    if ({rValid, rLast, sent} !== 3'b100) begin
      nMismatch++; $display("[TB] FAIL rst_beat2: got valid=%b last=%b sent=%b expected 1 0 0", rValid, rLast, sent);
    end
    #1;
    rst_n = 0;
    #1;
    nCompared++;
    if ({rValid, rResp, rLast, rId, sent, arValid} !== '0) begin
      nMismatch++; $display("[TB] FAIL rst_async: got valid=%b resp=%b id=%h sent=%b expected 0", rValid, rResp, rId, sent);
    end
    drop = 0; rReady = 0;
    cyc();
    rst_n = 1;
    repeat (3) begin cyc(); @(negedge clk); end
    nCompared++;
    if ((sentCnt - sent0) !== 0 || rValid !== 1'b0 || arValid !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL rst_no_sent: got sent=%0d valid=%b/%b expected 0", sentCnt - sent0, rValid, arValid);
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    accept = 1; addr = 40'h00_0000_1000; id = 8'h01; len = 8'd0; coh = 1; arReady = 1;
    @(negedge clk);
    cyc(); @(negedge clk);
    nCompared++;
    if ({arValid, sent} !== 2'b11) begin
      nMismatch++; $display("[TB] FAIL b2b_fwd: got valid=%b sent=%b expected 1 1", arValid, sent);
    end
    cyc();
    accept = 0; drop = 1; id = 8'h07; len = 8'd0; rReady = 1;
    @(negedge clk);
    nCompared++;
    if ({arValid, rValid} !== 2'b00) begin
      nMismatch++; $display("[TB] FAIL b2b_idle: got ar=%b r=%b expected 0 0", arValid, rValid);
    end
    cyc(); @(negedge clk);
    nCompared++;
    if ({rValid, rLast, rId, sent, arValid} !== {1'b1, 1'b1, 8'h07, 1'b1, 1'b0}) begin
      nMismatch++; $display("[TB] FAIL b2b_err: got valid=%b last=%b id=%h sent=%b ar=%b", rValid, rLast, rId, sent, arValid);
    end
    cyc();
    drop = 0; rReady = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_backpressure();
    test_drop();
    test_drop_long();
    test_priority();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
